rr_arb8: RTL and testbench

- Round-robin arbiter/scheduler that shares one downstream resource among 8 requesters. The resource is an 8-to-3 encoder path or any shared datapath.
- Produces a registered one-hot grant, its 3-bit binary index and a valid flag.
- Enforces fairness and a maximum hold time so no requester can monopolise the resource.
- Sits between the request sources and the shared datapath; gidx drives the datapath select directly.

---
 rtl/rr_arb8.sv | 138 +++++++++++++
 tb/tb_rr_arb8.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/rr_arb8.sv
// rtl/rr_arb8.sv - 8-way round-robin arbiter with maximum hold time
//
// Shares one downstream resource among 8 requesters. The grant is registered,
// one-hot, and comes with a binary index that drives the datapath select.
// Fairness comes from a rotating scan start (ptr). A hold counter revokes a
// grant after MAX_HOLD cycles so no requester can keep the resource forever.
//
// Ports:
//   clk      in   rising-edge clock
//   rst_n    in   synchronous active-low reset
//   en       in   arbitration enable; low drops any grant and stays idle
//   req[7:0] in   request vector, req[i] high = requester i wants the resource
//   gnt[7:0] out  registered one-hot grant, 8'h00 when idle
//   gidx[2:0] out binary index of the granted requester, 0 when idle
//   gvalid   out  high while a grant is active (equals |gnt)
//   to_pulse out  one-cycle pulse after a grant is revoked by hold timeout

module rr_arb8 #(
  parameter int MAX_HOLD = 16,
  parameter int CW       = $clog2(MAX_HOLD)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic [2:0] gidx,
  output logic       gvalid,
  output logic       to_pulse
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state, state_nx;
  logic [2:0]      ptr, ptr_nx;
  logic [CW-1:0]   hold_cnt, hold_nx;
  logic [7:0]      gnt_nx;
  logic [2:0]      gidx_nx;
  logic            gvalid_nx;
  logic            to_nx;

  // Next-grant selection: rotate req so ptr lands on bit 0, take the lowest
  // set bit, then add ptr back (3-bit wrap) to recover the real index.
  logic [15:0]     dbl;
  logic [7:0]      rot;
  logic [2:0]      off;
  logic [2:0]      pick;
  logic            any_req;
  logic            timeout;

  always_comb begin
    dbl = {req, req} >> ptr;
    rot = dbl[7:0];
    off = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (rot[i]) off = 3'(i);
    end
    pick    = ptr + off;
    any_req = |req;
    timeout = (hold_cnt == CW'(MAX_HOLD - 1));
  end

  always_comb begin
    state_nx  = state;
    ptr_nx    = ptr;
    hold_nx   = hold_cnt;
    gnt_nx    = gnt;
    gidx_nx   = gidx;
    gvalid_nx = gvalid;
    to_nx     = 1'b0;
    case (state)
      IDLE: begin
        gnt_nx    = 8'h00;
        gidx_nx   = 3'd0;
        gvalid_nx = 1'b0;
        if (en && any_req) begin
          state_nx  = GRANT;
          gnt_nx    = 8'd1 << pick;
          gidx_nx   = pick;
          gvalid_nx = 1'b1;
          hold_nx   = '0;
        end
      end
      GRANT: begin
        if (!en) begin
          // Disable drops the grant without advancing the scan start.
          state_nx  = IDLE;
          gnt_nx    = 8'h00;
          gidx_nx   = 3'd0;
          gvalid_nx = 1'b0;
        end else if (!req[gidx]) begin
          // Release wins over a coincident timeout, so no pulse here.
          state_nx  = IDLE;
          ptr_nx    = gidx + 3'd1;
          gnt_nx    = 8'h00;
          gidx_nx   = 3'd0;
          gvalid_nx = 1'b0;
        end else if (timeout) begin
          state_nx  = IDLE;
          ptr_nx    = gidx + 3'd1;
          gnt_nx    = 8'h00;
          gidx_nx   = 3'd0;
          gvalid_nx = 1'b0;
          to_nx     = 1'b1;
        end else begin
          hold_nx = hold_cnt + CW'(1);
        end
      end
      default: begin
        state_nx  = IDLE;
        gnt_nx    = 8'h00;
        gidx_nx   = 3'd0;
        gvalid_nx = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= 3'd0;
      hold_cnt <= '0;
      gnt      <= 8'h00;
      gidx     <= 3'd0;
      gvalid   <= 1'b0;
      to_pulse <= 1'b0;
    end else begin
      state    <= state_nx;
      ptr      <= ptr_nx;
      hold_cnt <= hold_nx;
      gnt      <= gnt_nx;
      gidx     <= gidx_nx;
      gvalid   <= gvalid_nx;
      to_pulse <= to_nx;
    end
  end

endmodule

// File: tb/tb_rr_arb8.sv
// tb/tb_rr_arb8.sv - self-checking bench for rr_arb8 (MAX_HOLD=4)

module tb_rr_arb8;

  localparam int MH = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gidx;
  logic       gvalid;
  logic       to_pulse;

  int vectors = 0;
  int miscompares = 0;

  rr_arb8 #(.MAX_HOLD(MH)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req),
    .gnt(gnt), .gidx(gidx), .gvalid(gvalid), .to_pulse(to_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: who owns the resource, how many cycles it has been
  // visible, and where the next circular scan begins.
  int         m_owner = -1;
  int         m_age = 0;
  int         m_ptr = 0;
  bit         m_to = 1'b0;
  logic [7:0] e_gnt;
  logic [2:0] e_idx;

  always @(posedge clk) begin
    m_to = 1'b0;
    if (!rst_n) begin
      m_owner = -1;
      m_age   = 0;
      m_ptr   = 0;
    end else if (m_owner < 0) begin
      if (en && req != 8'h00) begin
        for (int k = 7; k >= 0; k--) begin
          if (req[(m_ptr + k) % 8]) m_owner = (m_ptr + k) % 8;
        end
        m_age = 1;
      end
    end else begin
      if (!en) begin
        m_owner = -1;
      end else if (!req[m_owner]) begin
        m_ptr   = (m_owner + 1) % 8;
        m_owner = -1;
      end else if (m_age == MH) begin
        m_ptr   = (m_owner + 1) % 8;
        m_owner = -1;
        m_to    = 1'b1;
      end else begin
        m_age = m_age + 1;
      end
    end
    #1;
    e_gnt = (m_owner < 0) ? 8'h00 : (8'd1 << m_owner);
    e_idx = (m_owner < 0) ? 3'd0 : 3'(m_owner);
    chk("cycle {gnt,gidx,gvalid,to_pulse}",
        {19'd0, gnt, gidx, gvalid, to_pulse},
        {19'd0, e_gnt, e_idx, (m_owner >= 0), m_to});
  end

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic pin(input string name, input logic [7:0] g, input logic [2:0] ix, input logic tp);
    chk({name, " gnt"}, {24'd0, gnt}, {24'd0, g});
    chk({name, " gidx"}, {29'd0, gidx}, {29'd0, ix});
    chk({name, " gvalid"}, {31'd0, gvalid}, {31'd0, (g != 8'h00)});
    chk({name, " to_pulse"}, {31'd0, to_pulse}, {31'd0, tp});
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; req = 8'hFF;
    // 1: reset while requests are active
    step(2);
    pin("t1 reset", 8'h00, 3'd0, 1'b0);
    rst_n = 1'b1;
    step();
    pin("t1 first grant", 8'h01, 3'd0, 1'b0);
    en = 1'b0; req = 8'h00;
    step();
    en = 1'b1;

    // 2: single request, release, scan moves past it
    req = 8'h08;
    step();
    pin("t2 grant 3", 8'h08, 3'd3, 1'b0);
    step();
    req = 8'h00;
    step();
    pin("t2 release", 8'h00, 3'd0, 1'b0);
    req = 8'h18;
    step();
    pin("t2 ptr4", 8'h10, 3'd4, 1'b0);
    req = 8'h00;
    step();

    // 3: two requesters alternate on timeout, wrap 7->0
    rst_n = 1'b0; step(); rst_n = 1'b1;
    req = 8'h81;
    step();
    pin("t3 g0 first", 8'h01, 3'd0, 1'b0);
    step(3);
    pin("t3 g0 fourth", 8'h01, 3'd0, 1'b0);
    step();
    pin("t3 timeout0", 8'h00, 3'd0, 1'b1);
    step();
    pin("t3 g7", 8'h80, 3'd7, 1'b0);
    step(3);
    pin("t3 g7 fourth", 8'h80, 3'd7, 1'b0);
    step();
    pin("t3 timeout7", 8'h00, 3'd0, 1'b1);
    step();
    pin("t3 wrap g0", 8'h01, 3'd0, 1'b0);
    req = 8'h00;
    step();

    // 4: sole requester re-granted every 5 cycles
    req = 8'h20;
    step();
    pin("t4 g5", 8'h20, 3'd5, 1'b0);
    step(4);
    pin("t4 timeout", 8'h00, 3'd0, 1'b1);
    step();
    pin("t4 regrant", 8'h20, 3'd5, 1'b0);
    step(4);
    pin("t4 timeout2", 8'h00, 3'd0, 1'b1);
    req = 8'h00;
    step();

    // 5: enable drop keeps ptr at 0
    rst_n = 1'b0; step(); rst_n = 1'b1;
    req = 8'h04;
    step();
    pin("t5 g2", 8'h04, 3'd2, 1'b0);
    en = 1'b0;
    step();
    pin("t5 en drop", 8'h00, 3'd0, 1'b0);
    en = 1'b1; req = 8'h05;
    step();
    pin("t5 ptr0", 8'h01, 3'd0, 1'b0);
    req = 8'h00;
    step();

    // 6: reset mid-grant, then release on the timeout edge
    req = 8'h04;
    step(3);
    pin("t6 held", 8'h04, 3'd2, 1'b0);
    rst_n = 1'b0;
    step();
    pin("t6 reset", 8'h00, 3'd0, 1'b0);
    rst_n = 1'b1;
    step();
    pin("t6 fresh", 8'h04, 3'd2, 1'b0);
    step(3);
    pin("t6 fourth", 8'h04, 3'd2, 1'b0);
    req = 8'h00;
    step();
    pin("t6 collision", 8'h00, 3'd0, 1'b0);

    // Random phase: requests mostly stable so timeouts occur
    for (int c = 0; c < 3000; c++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      en    = ($urandom_range(0, 15) != 0);
      case ($urandom_range(0, 7))
        0:       req = 8'(1 << $urandom_range(0, 7));
        1:       req = 8'($urandom);
        2:       req = 8'h00;
        default: req = req;
      endcase
      step();
    end
    rst_n = 1'b1; en = 1'b0; req = 8'h00;
    step(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
